// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 bus sequencer: state encoding,
// power-up init ROM and the clear/home command codes.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_IDLE  = 3'd6
    } lcd_state_e;

    localparam int INIT_LEN = 4;

    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INIT_FUNC_SET;
            2'd1:    b = INIT_DISP_ON;
            2'd2:    b = INIT_CLEAR;
            default: b = INIT_ENTRY;
        endcase
        return b;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Only clear/home written to the instruction register need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every sequencer phase; holds at zero and
// reports whether the count will be zero after the coming clock edge.
module lcd_phase_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         next_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero      = (cnt == '0);
    assign next_zero = load ? (load_val == '0) : (cnt <= W'(1));

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 write-only bus sequencer: setup / E strobe / hold / execution wait per byte.
// Define LCD_CTRL_INIT_EN to run the power-up wait and 4-byte init ROM after reset.
module lcd_bus_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 16,
    parameter int HOLD_CYC  = 4,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int PWR_WAIT  = 750000
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic       iREQ,
    input  logic       iRS,
    input  logic [7:0] iDATA,
    output logic       oREADY,
    output logic       oDONE,
    output logic       oINIT_DONE,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [2:0] oDBG_STATE
);

    localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_CYC), max_of(HOLD_CYC, CMD_WAIT)),
                                    max_of(CLR_WAIT, PWR_WAIT));
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] L_EN    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] L_CMD   = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] L_CLR   = CW'(CLR_WAIT - 1);

`ifdef LCD_CTRL_INIT_EN
    localparam logic [CW-1:0] L_PWR      = CW'(PWR_WAIT - 1);
    localparam lcd_state_e    RST_STATE  = ST_PWR;
    localparam logic          RST_READY  = 1'b0;
    localparam logic          RST_INIT   = 1'b0;
    localparam logic [CW-1:0] RST_CNT    = L_PWR;
    localparam logic [1:0]    IDX_LAST   = 2'(INIT_LEN - 1);
`else
    localparam lcd_state_e    RST_STATE  = ST_IDLE;
    localparam logic          RST_READY  = 1'b1;
    localparam logic          RST_INIT   = 1'b1;
    localparam logic [CW-1:0] RST_CNT    = '0;
`endif

    lcd_state_e    state, state_nxt;
    logic          tmr_load, tmr_zero, tmr_next_zero;
    logic [CW-1:0] tmr_val;
    logic          rs_nxt, init_nxt, done_nxt;
    logic [7:0]    data_nxt;

`ifdef LCD_CTRL_INIT_EN
    logic [1:0] idx, idx_nxt;

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) idx <= 2'd0;
        else         idx <= idx_nxt;
    end
`endif

    lcd_phase_timer #(.W(CW), .RST_VAL(RST_CNT)) u_timer (
        .clk       (iCLK_50MHZ),
        .rst_n     (iRST_N),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .zero      (tmr_zero),
        .next_zero (tmr_next_zero)
    );

    // Handshake: a byte moves on any edge where iREQ && oREADY; oREADY is a
    // registered copy of "next state is IDLE", so it never depends on iREQ.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        rs_nxt    = LCD_RS;
        data_nxt  = LCD_DATA;
        init_nxt  = oINIT_DONE;
`ifdef LCD_CTRL_INIT_EN
        idx_nxt   = idx;
`endif
        case (state)
`ifdef LCD_CTRL_INIT_EN
            ST_PWR: begin
                if (tmr_zero) begin
                    state_nxt = ST_LOAD;
                    tmr_load  = 1'b1;
                end
            end
            ST_LOAD: begin
                rs_nxt    = 1'b0;
                data_nxt  = init_rom(idx);
                state_nxt = ST_SETUP;
                tmr_load  = 1'b1;
                tmr_val   = L_SETUP;
            end
`endif
            ST_IDLE: begin
                if (iREQ && oREADY) begin
                    rs_nxt    = iRS;
                    data_nxt  = iDATA;
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_nxt = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = L_EN;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_nxt = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = is_long_cmd(LCD_RS, LCD_DATA) ? L_CLR : L_CMD;
                end
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    state_nxt = ST_IDLE;
`ifdef LCD_CTRL_INIT_EN
                    if (!oINIT_DONE) begin
                        if (idx == IDX_LAST) begin
                            init_nxt = 1'b1;
                        end else begin
                            idx_nxt   = idx + 2'd1;
                            state_nxt = ST_LOAD;
                        end
                    end
`endif
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // oDONE lands in the final WAIT cycle, one cycle ahead of oREADY.
    assign done_nxt = (state_nxt == ST_WAIT) && tmr_next_zero;

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= RST_STATE;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            oREADY     <= RST_READY;
            oDONE      <= 1'b0;
            oINIT_DONE <= RST_INIT;
        end else begin
            state      <= state_nxt;
            LCD_E      <= (state_nxt == ST_PULSE);
            LCD_RS     <= rs_nxt;
            LCD_DATA   <= data_nxt;
            oREADY     <= (state_nxt == ST_IDLE);
            oDONE      <= done_nxt;
            oINIT_DONE <= init_nxt;
        end
    end

    assign LCD_RW     = 1'b0;
    assign oDBG_STATE = state;

endmodule
